// File: rtl/shift_reg_en_pkg.sv
// Mode encodings and shared helpers for the enabled shift register.
package shift_reg_en_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_SHR  = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_ROR  = 3'b101,
    MODE_ASR  = 3'b110,
    MODE_CLR  = 3'b111
  } mode_t;

  // True for every mode that moves bits and therefore advances the shift count.
  function automatic logic is_shift_mode(input logic [2:0] m);
    return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ROL) ||
           (m == MODE_ROR) || (m == MODE_ASR);
  endfunction

  // True for modes that restart the shift count.
  function automatic logic is_restart_mode(input logic [2:0] m);
    return (m == MODE_LOAD) || (m == MODE_CLR);
  endfunction

endpackage

// File: rtl/shift_reg_en_dff.sv
// Single-bit flop with asynchronous active-low reset and clock enable.
module dff_r_en (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= 1'b0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/shift_reg_en.sv
// WIDTH-bit register with clock enable, mode-selected load/shift/rotate/clear,
// and a saturating count of shift operations since the last load or clear.
module shift_reg_en
  import shift_reg_en_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d_in,
  input  logic             s_in_l,
  input  logic             s_in_r,
  output logic [WIDTH-1:0] q,
  output logic             s_out_l,
  output logic             s_out_r,
  output logic [CNT_W-1:0] cnt,
  output logic             drained
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;
  logic [CNT_W-1:0] cnt_reg;

  always_comb begin
    q_next = q_reg;
    case (mode)
      MODE_HOLD: q_next = q_reg;
      MODE_LOAD: q_next = d_in;
      MODE_SHL:  q_next = {q_reg[WIDTH-2:0], s_in_l};
      MODE_SHR:  q_next = {s_in_r, q_reg[WIDTH-1:1]};
      MODE_ROL:  q_next = {q_reg[WIDTH-2:0], q_reg[WIDTH-1]};
      MODE_ROR:  q_next = {q_reg[0], q_reg[WIDTH-1:1]};
      MODE_ASR:  q_next = {q_reg[WIDTH-1], q_reg[WIDTH-1:1]};
      MODE_CLR:  q_next = '0;
      default:   q_next = q_reg;
    endcase
  end

  // The enable gates the flops directly, so en=0 holds q whatever the mux says.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      dff_r_en u_dff (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .d       (q_next[gi]),
        .q       (q_reg[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg <= '0;
    end else if (en) begin
      if (is_restart_mode(mode)) begin
        cnt_reg <= '0;
      end else if (is_shift_mode(mode) && (cnt_reg != CNT_FULL)) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign q       = q_reg;
  assign s_out_l = q_reg[WIDTH-1];
  assign s_out_r = q_reg[0];
  assign cnt     = cnt_reg;
  assign drained = (cnt_reg == CNT_FULL);

endmodule

// File: tb/tb_shift_reg_en.sv
// Directed, table-driven checks of shift_reg_en at WIDTH=8, CNT_W=4.
module tb_shift_reg_en;
  import shift_reg_en_pkg::*;

  logic       clk;
  logic       reset_n;
  logic       en;
  logic [2:0] mode;
  logic [7:0] d_in;
  logic       s_in_l;
  logic       s_in_r;
  logic [7:0] q;
  logic       s_out_l;
  logic       s_out_r;
  logic [3:0] cnt;
  logic       drained;

  int checks = 0;
  int errors = 0;

  shift_reg_en #(.WIDTH(8), .CNT_W(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .mode    (mode),
    .d_in    (d_in),
    .s_in_l  (s_in_l),
    .s_in_r  (s_in_r),
    .q       (q),
    .s_out_l (s_out_l),
    .s_out_r (s_out_r),
    .cnt     (cnt),
    .drained (drained)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [2:0] mode;
    logic [7:0] d_in;
    logic       s_in_l;
    logic       s_in_r;
    logic [7:0] exp_q;
    logic [3:0] exp_cnt;
    logic       exp_drained;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string name, input logic [7:0] eq,
                             input logic [3:0] ec, input logic ed);
    check({name, ".q"}, 32'(q), 32'(eq));
    check({name, ".cnt"}, 32'(cnt), 32'(ec));
    check({name, ".drained"}, 32'(drained), 32'(ed));
    check({name, ".s_out_l"}, 32'(s_out_l), 32'(eq[7]));
    check({name, ".s_out_r"}, 32'(s_out_r), 32'(eq[0]));
  endtask

  // Drive inputs, take one rising edge, settle just past it.
  task automatic step(input logic e, input logic [2:0] m, input logic [7:0] d,
                      input logic sl, input logic sr);
    en = e; mode = m; d_in = d; s_in_l = sl; s_in_r = sr;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[$];
  logic [7:0] ser_bits;

  initial begin
    reset_n = 1'b0; en = 1'b1; mode = MODE_LOAD; d_in = 8'hFF;
    s_in_l = 1'b0; s_in_r = 1'b0;

    // Reset dominates an active LOAD of all-ones.
    repeat (2) @(posedge clk);
    #1;
    check_state("reset", 8'h00, 4'd0, 1'b0);
    #3 reset_n = 1'b1;
    #1;

    vecs.push_back('{1'b1, MODE_LOAD, 8'hA5, 1'b0, 1'b0, 8'hA5, 4'd0, 1'b0});
    vecs.push_back('{1'b0, MODE_SHL,  8'h00, 1'b1, 1'b0, 8'hA5, 4'd0, 1'b0});
    vecs.push_back('{1'b0, MODE_SHL,  8'h00, 1'b1, 1'b0, 8'hA5, 4'd0, 1'b0});
    vecs.push_back('{1'b0, MODE_SHL,  8'h00, 1'b1, 1'b0, 8'hA5, 4'd0, 1'b0});
    vecs.push_back('{1'b1, MODE_SHL,  8'h00, 1'b1, 1'b0, 8'h4B, 4'd1, 1'b0});
    vecs.push_back('{1'b1, MODE_LOAD, 8'h81, 1'b0, 1'b0, 8'h81, 4'd0, 1'b0});
    vecs.push_back('{1'b1, MODE_ROL,  8'h00, 1'b0, 1'b0, 8'h03, 4'd1, 1'b0});
    vecs.push_back('{1'b1, MODE_ROR,  8'h00, 1'b0, 1'b0, 8'h81, 4'd2, 1'b0});
    vecs.push_back('{1'b1, MODE_ROL,  8'h00, 1'b0, 1'b0, 8'h03, 4'd3, 1'b0});
    vecs.push_back('{1'b1, MODE_ROL,  8'h00, 1'b0, 1'b0, 8'h06, 4'd4, 1'b0});
    vecs.push_back('{1'b1, MODE_ROL,  8'h00, 1'b0, 1'b0, 8'h0C, 4'd5, 1'b0});
    vecs.push_back('{1'b1, MODE_ROL,  8'h00, 1'b0, 1'b0, 8'h18, 4'd6, 1'b0});
    vecs.push_back('{1'b1, MODE_ROL,  8'h00, 1'b0, 1'b0, 8'h30, 4'd7, 1'b0});
    vecs.push_back('{1'b1, MODE_ROL,  8'h00, 1'b0, 1'b0, 8'h60, 4'd8, 1'b1});
    vecs.push_back('{1'b1, MODE_ROL,  8'h00, 1'b0, 1'b0, 8'hC0, 4'd8, 1'b1});
    vecs.push_back('{1'b1, MODE_HOLD, 8'h55, 1'b1, 1'b1, 8'hC0, 4'd8, 1'b1});
    vecs.push_back('{1'b1, MODE_LOAD, 8'h90, 1'b0, 1'b0, 8'h90, 4'd0, 1'b0});
    vecs.push_back('{1'b1, MODE_ASR,  8'h00, 1'b0, 1'b0, 8'hC8, 4'd1, 1'b0});
    vecs.push_back('{1'b1, MODE_ASR,  8'h00, 1'b0, 1'b0, 8'hE4, 4'd2, 1'b0});
    vecs.push_back('{1'b1, MODE_LOAD, 8'h5A, 1'b0, 1'b0, 8'h5A, 4'd0, 1'b0});
    vecs.push_back('{1'b1, MODE_SHL,  8'h00, 1'b0, 1'b0, 8'hB4, 4'd1, 1'b0});
    vecs.push_back('{1'b1, MODE_SHL,  8'h00, 1'b0, 1'b0, 8'h68, 4'd2, 1'b0});
    vecs.push_back('{1'b1, MODE_SHL,  8'h00, 1'b0, 1'b0, 8'hD0, 4'd3, 1'b0});
    vecs.push_back('{1'b1, MODE_CLR,  8'hFF, 1'b1, 1'b1, 8'h00, 4'd0, 1'b0});
    vecs.push_back('{1'b1, MODE_LOAD, 8'h3C, 1'b0, 1'b0, 8'h3C, 4'd0, 1'b0});
    vecs.push_back('{1'b1, MODE_SHR,  8'h00, 1'b0, 1'b1, 8'h9E, 4'd1, 1'b0});

    foreach (vecs[i]) begin
      step(vecs[i].en, vecs[i].mode, vecs[i].d_in, vecs[i].s_in_l, vecs[i].s_in_r);
      check_state($sformatf("vec%0d", i), vecs[i].exp_q, vecs[i].exp_cnt, vecs[i].exp_drained);
    end

    // Serialise C3 out of bit 0; bits observed before each shift, LSB first.
    step(1'b1, MODE_LOAD, 8'hC3, 1'b0, 1'b0);
    ser_bits = 8'b1100_0011;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("ser_bit%0d", i), 32'(s_out_r), 32'(ser_bits[i]));
      step(1'b1, MODE_SHR, 8'h00, 1'b0, 1'b0);
    end
    check_state("ser_done", 8'h00, 4'd8, 1'b1);
    step(1'b1, MODE_SHR, 8'h00, 1'b0, 1'b0);
    check_state("ser_sat", 8'h00, 4'd8, 1'b1);

    // Asynchronous reset between edges, mid-shift.
    step(1'b1, MODE_LOAD, 8'h5A, 1'b0, 1'b0);
    step(1'b1, MODE_SHL, 8'h00, 1'b0, 1'b0);
    step(1'b1, MODE_SHL, 8'h00, 1'b0, 1'b0);
    check_state("pre_arst", 8'h68, 4'd2, 1'b0);
    #1 reset_n = 1'b0;
    #1;
    check_state("arst_now", 8'h00, 4'd0, 1'b0);
    #1 reset_n = 1'b1;
    step(1'b1, MODE_HOLD, 8'hFF, 1'b1, 1'b1);
    check_state("arst_after", 8'h00, 4'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
